video_address_gen: RTL and testbench

- Generates the 13-bit display-memory address (DA12..DA0) for the MC6847X core.
- Sits directly downstream of FrameTiming. Consumes its hsn, fsn and preload strobes, and drives the top-level DA0 pin plus the full address to the memory interface.
- Implements per-mode row repetition, so each memory row is fetched the correct number of scanlines: alpha ×12, graphics ×3, ×2 or ×1.
- Bytes per row are 16 or 32, selected by mode.

---
 rtl/video_address_gen.sv | 127 ++++++++++++
 tb/tb_video_address_gen.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_address_gen.sv
// video_address_gen
// -----------------------------------------------------------------------------
// Display-memory address generator for the MC6847X core. Sits behind
// FrameTiming and turns its sync strobes plus the per-byte preload strobe into
// the 13-bit display address. Each memory row is refetched for a mode-dependent
// number of scanlines: alpha x12, graphics x3/x2/x1. A row is 16 or 32 bytes.
//
// Ports:
//   clk        video clock (shared with FrameTiming)
//   rst        synchronous reset, active-high
//   fsn        frame sync, active-low; falling edge restarts the frame at 0
//   hsn        horizontal sync, active-low; falling edge ends a scanline
//   preload    one-cycle strobe: step to the next data byte
//   ag         1 = graphics, 0 = alpha/semigraphics
//   gm[2:0]    graphics mode 0..7
//   da         current display address
//   da0        da[0], for the top-level DA0 pin
//   row_phase  scanline index inside the current repeat group
//   row_done   one-cycle pulse when a repeat group completes
//
// Strobe semantics: preload is a single-cycle request with no back-pressure.
// It is accepted only on a cycle without an fsn/hsn falling edge and only while
// fewer than bytes_per_row bytes have been fetched on the current line; any
// other preload is dropped.
// -----------------------------------------------------------------------------
module video_address_gen #(
  parameter int ADDR_W       = 13,
  parameter int ALPHA_REPEAT = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fsn,
  input  logic              hsn,
  input  logic              preload,
  input  logic              ag,
  input  logic [2:0]        gm,
  output logic [ADDR_W-1:0] da,
  output logic              da0,
  output logic [3:0]        row_phase,
  output logic              row_done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        ALPHA_REP = 4'(ALPHA_REPEAT);

  logic              hsn_q;
  logic              fsn_q;
  logic [ADDR_W-1:0] row_base;
  logic [5:0]        byte_cnt;
  logic [3:0]        rep_q;
  logic [5:0]        bytes_q;

  logic              fsn_fall;
  logic              hsn_fall;
  logic [3:0]        mode_rep;
  logic [5:0]        mode_bytes;

  assign fsn_fall = fsn_q & ~fsn;
  assign hsn_fall = hsn_q & ~hsn;
  assign da0      = da[0];

  // Mode decode from the live ag/gm pins; only sampled into rep_q/bytes_q on
  // sync edges so a mid-line mode change waits for the next line.
  always_comb begin
    mode_rep   = ALPHA_REP;
    mode_bytes = 6'd32;
    if (ag) begin
      case (gm)
        3'd0:    begin mode_rep = 4'd3; mode_bytes = 6'd16; end
        3'd1:    begin mode_rep = 4'd3; mode_bytes = 6'd16; end
        3'd2:    begin mode_rep = 4'd3; mode_bytes = 6'd32; end
        3'd3:    begin mode_rep = 4'd2; mode_bytes = 6'd16; end
        3'd4:    begin mode_rep = 4'd2; mode_bytes = 6'd32; end
        3'd5:    begin mode_rep = 4'd1; mode_bytes = 6'd16; end
        default: begin mode_rep = 4'd1; mode_bytes = 6'd32; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsn_q     <= 1'b1;
      fsn_q     <= 1'b1;
      da        <= '0;
      row_base  <= '0;
      byte_cnt  <= '0;
      row_phase <= '0;
      row_done  <= 1'b0;
      rep_q     <= ALPHA_REP;
      bytes_q   <= 6'd32;
    end else begin
      hsn_q    <= hsn;
      fsn_q    <= fsn;
      row_done <= 1'b0;

      if (fsn_fall) begin
        da        <= '0;
        row_base  <= '0;
        byte_cnt  <= '0;
        row_phase <= '0;
        rep_q     <= mode_rep;
        bytes_q   <= mode_bytes;
      end else if (hsn_fall) begin
        byte_cnt <= '0;
        rep_q    <= mode_rep;
        bytes_q  <= mode_bytes;
        // A line with no fetches is blanking and does not count as a repeat.
        if (byte_cnt != 6'd0) begin
          // ">=" rather than "==" so that switching to a shorter repeat while
          // row_phase is already past it still closes the group.
          if (row_phase >= (rep_q - 4'd1)) begin
            row_phase <= '0;
            row_base  <= da;
            row_done  <= 1'b1;
          end else begin
            row_phase <= row_phase + 4'd1;
            da        <= row_base;
          end
        end
      end else if (preload && (byte_cnt < bytes_q)) begin
        da       <= da + ADDR_ONE;
        byte_cnt <= byte_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_address_gen.sv
// tb_video_address_gen
// Drives frames/lines of preload strobes into video_address_gen. Every driven
// cycle advances a behavioural reference model and pushes the expected
// {da, row_phase, row_done} into exp_q; a monitor pops one entry per clock and
// compares. Directed checks against hand-derived constants are mixed in.
module tb_video_address_gen;

  localparam int ADDR_W = 13;
  localparam int W      = ADDR_W + 4 + 1;
  localparam int AMOD   = 1 << ADDR_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fsn = 1'b1;
  logic              hsn = 1'b1;
  logic              preload = 1'b0;
  logic              ag = 1'b0;
  logic [2:0]        gm = 3'd0;
  logic [ADDR_W-1:0] da;
  logic              da0;
  logic [3:0]        row_phase;
  logic              row_done;

  always #5 clk = ~clk;

  video_address_gen #(.ADDR_W(ADDR_W), .ALPHA_REPEAT(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .fsn       (fsn),
    .hsn       (hsn),
    .preload   (preload),
    .ag        (ag),
    .gm        (gm),
    .da        (da),
    .da0       (da0),
    .row_phase (row_phase),
    .row_done  (row_done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected simulation end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : monitor
    logic [W-1:0] e;
    #1;
    if (row_done === 1'b1) done_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_da",        32'(da),        32'(e[W-1:5]));
      check("sb_da0",       32'(da0),       32'(e[5]));
      check("sb_row_phase", 32'(row_phase), 32'(e[4:1]));
      check("sb_row_done",  32'(row_done),  32'(e[0]));
    end
  end

  // ---------------- reference model ----------------
  // Mode table: index = gm for graphics; alpha handled separately.
  int rep_tab   [8] = '{3, 3, 3, 2, 2, 1, 1, 1};
  int bytes_tab [8] = '{16, 16, 32, 16, 32, 16, 32, 32};

  int m_addr, m_base, m_cnt, m_phase, m_rep, m_bytes;
  bit m_done, m_fsn_prev, m_hsn_prev;
  bit       cur_ag = 1'b0;
  bit [2:0] cur_gm = 3'd0;

  task automatic model_latch_mode();
    if (!cur_ag) begin
      m_rep = 12; m_bytes = 32;
    end else begin
      m_rep = rep_tab[cur_gm]; m_bytes = bytes_tab[cur_gm];
    end
  endtask

  task automatic model_step(input bit r, input bit f, input bit h, input bit p);
    bit f_fall, h_fall;
    m_done = 1'b0;
    if (r) begin
      m_addr = 0; m_base = 0; m_cnt = 0; m_phase = 0;
      m_rep = 12; m_bytes = 32;
      m_fsn_prev = 1'b1; m_hsn_prev = 1'b1;
    end else begin
      f_fall = m_fsn_prev && !f;
      h_fall = m_hsn_prev && !h;
      if (f_fall) begin
        m_addr = 0; m_base = 0; m_cnt = 0; m_phase = 0;
        model_latch_mode();
      end else if (h_fall) begin
        if (m_cnt > 0) begin
          if (m_phase + 1 >= m_rep) begin
            m_phase = 0; m_base = m_addr; m_done = 1'b1;
          end else begin
            m_phase = m_phase + 1; m_addr = m_base;
          end
        end
        m_cnt = 0;
        model_latch_mode();
      end else if (p && m_cnt < m_bytes) begin
        m_addr = (m_addr + 1) % AMOD;
        m_cnt  = m_cnt + 1;
      end
      m_fsn_prev = f;
      m_hsn_prev = h;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit r, input bit f, input bit h, input bit p);
    logic [ADDR_W-1:0] ea;
    logic [3:0]        ep;
    @(negedge clk);
    rst = r; fsn = f; hsn = h; preload = p; ag = cur_ag; gm = cur_gm;
    model_step(r, f, h, p);
    ea = ADDR_W'(m_addr);
    ep = 4'(m_phase);
    exp_q.push_back({ea, ep, m_done});
  endtask

  // Wait until the last driven cycle has been clocked in (after the monitor).
  task automatic sync_point();
    @(posedge clk);
    #2;
  endtask

  task automatic frame_start(input bit a, input bit [2:0] g);
    cur_ag = a; cur_gm = g;
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
  endtask

  task automatic preloads(input int n);
    repeat (n) cyc(0, 1, 1, 1);
  endtask

  task automatic hsn_edge(input bit p);
    cyc(0, 1, 0, p);
    cyc(0, 1, 1, 0);
  endtask

  task automatic line(input int n);
    preloads(n);
    hsn_edge(1'b0);
  endtask

  // ---------------- stimulus ----------------
  int d0;
  int exp_gm3 [4] = '{0, 16, 16, 32};

  initial begin : driver
    // Reset
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    sync_point();
    check("rst_da", 32'(da), 0);
    check("rst_da0", 32'(da0), 0);
    check("rst_row_phase", 32'(row_phase), 0);
    check("rst_row_done", 32'(row_done), 0);
    cyc(0, 1, 1, 0);

    // Alpha: 12 lines per row, 32 bytes
    frame_start(1'b0, 3'd0);
    preloads(32);
    sync_point();
    check("alpha_first_fetch_da", 32'(da), 32);
    check("alpha_first_fetch_da0", 32'(da0), 0);
    d0 = done_seen;
    hsn_edge(1'b0);
    sync_point();
    check("alpha_line1_rewind_da", 32'(da), 0);
    check("alpha_line1_phase", 32'(row_phase), 1);
    repeat (10) line(32);
    sync_point();
    check("alpha_line11_phase", 32'(row_phase), 11);
    check("alpha_line11_da", 32'(da), 0);
    line(32);
    sync_point();
    check("alpha_line12_da", 32'(da), 32);
    check("alpha_line12_phase", 32'(row_phase), 0);
    check("alpha_line12_dones", 32'(done_seen - d0), 1);
    repeat (180) line(32);
    sync_point();
    check("alpha_192_da", 32'(da), 512);
    check("alpha_192_dones", 32'(done_seen - d0), 16);

    // gm3: x2, 16 bytes
    frame_start(1'b1, 3'd3);
    d0 = done_seen;
    for (int i = 0; i < 4; i++) begin
      line(16);
      sync_point();
      check($sformatf("gm3_line%0d_da", i + 1), 32'(da), 32'(exp_gm3[i]));
    end
    check("gm3_dones", 32'(done_seen - d0), 2);

    // gm7: x1, 32 bytes, run past the top of memory
    frame_start(1'b1, 3'd7);
    d0 = done_seen;
    repeat (192) line(32);
    sync_point();
    check("gm7_192_da", 32'(da), 6144);
    check("gm7_192_phase", 32'(row_phase), 0);
    check("gm7_192_dones", 32'(done_seen - d0), 192);
    repeat (63) line(32);
    preloads(31);
    sync_point();
    check("wrap_top_da", 32'(da), 8191);
    preloads(1);
    sync_point();
    check("wrap_zero_da", 32'(da), 0);
    hsn_edge(1'b0);
    sync_point();
    check("wrap_line_end_da", 32'(da), 0);

    // gm5 overrun guard, then preload coincident with hsn edge
    frame_start(1'b1, 3'd5);
    preloads(20);
    sync_point();
    check("overrun_da", 32'(da), 16);
    hsn_edge(1'b0);
    preloads(10);
    hsn_edge(1'b1);
    sync_point();
    check("preload_on_hsn_da", 32'(da), 26);

    // fsn and hsn edges together mid-group
    frame_start(1'b0, 3'd0);
    line(32);
    preloads(5);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 0);
    sync_point();
    check("fsn_hsn_same_da", 32'(da), 0);
    check("fsn_hsn_same_phase", 32'(row_phase), 0);

    // Mode switch to a shorter repeat while row_phase is past it
    frame_start(1'b0, 3'd0);
    repeat (5) line(32);
    sync_point();
    check("switch_pre_phase", 32'(row_phase), 5);
    cur_ag = 1'b1; cur_gm = 3'd3;
    line(32);
    sync_point();
    check("switch_old_rep_phase", 32'(row_phase), 6);
    line(16);
    sync_point();
    check("switch_close_da", 32'(da), 16);
    check("switch_close_phase", 32'(row_phase), 0);

    // Reset mid-line
    frame_start(1'b1, 3'd7);
    repeat (3) line(32);
    preloads(4);
    sync_point();
    check("midline_da", 32'(da), 100);
    cyc(1, 1, 1, 0);
    sync_point();
    check("midline_rst_da", 32'(da), 0);
    check("midline_rst_phase", 32'(row_phase), 0);
    cyc(0, 1, 1, 0);

    // Randomized frames: random modes, gaps, overruns, mid-line mode changes
    for (int fr = 0; fr < 6; fr++) begin
      frame_start(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      for (int ln = 0; ln < int'($urandom_range(3, 30)); ln++) begin
        int n, chg;
        n   = $urandom_range(0, 40);
        chg = $urandom_range(0, 60);
        for (int i = 0; i < n; i++) begin
          if (i == chg) begin
            cur_ag = 1'($urandom_range(0, 1));
            cur_gm = 3'($urandom_range(0, 7));
          end
          preloads(1);
          repeat ($urandom_range(0, 2)) cyc(0, 1, 1, 0);
        end
        hsn_edge(1'($urandom_range(0, 1)));
      end
      // Unconstrained pin activity, including coincident edges
      repeat (40) begin
        cur_ag = 1'($urandom_range(0, 1));
        cur_gm = 3'($urandom_range(0, 7));
        cyc(0, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)));
      end
      cyc(0, 1, 1, 0);
    end

    cyc(0, 1, 1, 0);
    sync_point();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
